multdiv_seq: RTL and testbench



---
 rtl/multdiv_pkg.sv | 16 +
 rtl/div_step.sv | 23 ++
 rtl/multdiv_seq.sv | 178 +++++++++++++++++
 tb/tb_multdiv_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared widths, state/op encodings and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned MD_W     = 32;
  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned MD_CNT_W = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;
  typedef enum logic {OP_MULT, OP_DIV} md_op_t;

  // Magnitude of a two's-complement value; 0x80000000 maps to itself as unsigned 2^31.
  function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] x);
    return x[MD_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import multdiv_pkg::*;
(
  input  logic [MD_W-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [MD_W-1:0] divisor,
  output logic [MD_W-1:0] rem_out,
  output logic            q_bit
);

  logic [MD_W:0] shifted;
  logic [MD_W:0] diff;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    // Borrow out of the top bit means the trial subtraction went negative.
    q_bit   = ~diff[MD_W];
    rem_out = q_bit ? diff[MD_W-1:0] : shifted[MD_W-1:0];
  end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// Divide datapath is present only when MULTDIV_DIV_EN is defined.
module multdiv_seq
  import multdiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic [MD_W-1:0] data_operandA,
  input  logic [MD_W-1:0] data_operandB,
  input  logic            ctrl_MULT,
  input  logic            ctrl_DIV,
  output logic [MD_W-1:0] data_result,
  output logic            data_exception,
  output logic            data_resultRDY,
  output logic            busy
);

  md_state_t             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  md_op_t                op_q, op_d;
  logic [MD_W-1:0]       mcand_q, mcand_d;
  logic [2*MD_W:0]       prod_q, prod_d;
  logic [MD_W-1:0]       result_q, result_d;
  logic                  exc_q, exc_d;

  logic                  last;
  logic [MD_W:0]         booth_sum;
  logic [2*MD_W:0]       booth_next;
  logic [2*MD_W-1:0]     product;

`ifdef MULTDIV_DIV_EN
  logic [MD_W-1:0] rem_q, rem_d;
  logic [MD_W-1:0] dvd_q, dvd_d;
  logic [MD_W-1:0] dsr_q, dsr_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;
  logic [MD_W-1:0] rem_nxt;
  logic            q_bit;
  logic [MD_W-1:0] quo;

  div_step u_div_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[MD_W-1]),
    .divisor (dsr_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );
`endif

  assign last = (cnt_q == MD_CNT_W'(MD_ITERS - 1));

  // Booth step on {acc, multiplier, q-1}; a 33-bit sum keeps the sign correct for -2^31.
  always_comb begin
    unique case (prod_q[1:0])
      2'b01:   booth_sum = {prod_q[2*MD_W], prod_q[2*MD_W:MD_W+1]} + {mcand_q[MD_W-1], mcand_q};
      2'b10:   booth_sum = {prod_q[2*MD_W], prod_q[2*MD_W:MD_W+1]} - {mcand_q[MD_W-1], mcand_q};
      default: booth_sum = {prod_q[2*MD_W], prod_q[2*MD_W:MD_W+1]};
    endcase
    booth_next = {booth_sum, prod_q[MD_W:1]};
    product    = booth_next[2*MD_W:1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef MULTDIV_DIV_EN
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    quo      = {dvd_q[MD_W-2:0], q_bit};
`endif

    case (state_q)
      RUN: begin
        cnt_d = cnt_q + MD_CNT_W'(1);
        if (op_q == OP_MULT) begin
          prod_d = booth_next;
          if (last) begin
            result_d = product[MD_W-1:0];
            exc_d    = product[2*MD_W-1:MD_W] != {MD_W{product[MD_W-1]}};
          end
        end
`ifdef MULTDIV_DIV_EN
        else begin
          // Quotient bits shift into the vacated low end of the dividend register.
          rem_d = rem_nxt;
          dvd_d = quo;
          if (last) begin
            if (dsr_q == '0) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else begin
              result_d = neg_q ? -quo : quo;
              exc_d    = ovf_q;
            end
          end
        end
`endif
        if (last) state_d = DONE;
      end

      IDLE, DONE: begin
        state_d = IDLE;
        if (ctrl_MULT) begin
          op_d    = OP_MULT;
          mcand_d = data_operandA;
          prod_d  = {{MD_W{1'b0}}, data_operandB, 1'b0};
          cnt_d   = '0;
          state_d = RUN;
        end else if (ctrl_DIV) begin
          op_d = OP_DIV;
`ifdef MULTDIV_DIV_EN
          rem_d   = '0;
          dvd_d   = md_abs(data_operandA);
          dsr_d   = md_abs(data_operandB);
          neg_d   = data_operandA[MD_W-1] ^ data_operandB[MD_W-1];
          ovf_d   = (data_operandA == {1'b1, {(MD_W-1){1'b0}}}) && (data_operandB == '1);
          cnt_d   = '0;
          state_d = RUN;
`else
          result_d = '0;
          exc_d    = 1'b1;
          state_d  = DONE;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MULTDIV_DIV_EN
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq; divide expectations follow MULTDIV_DIV_EN.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] opa, opb;
  logic        cm, cd;
  logic [31:0] res;
  logic        exc, rdy, bsy;

  int checks = 0;
  int passed = 0;

`ifdef MULTDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  localparam logic [31:0] MA [6] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000,
                                     32'hFFFF_FFFB, 32'h1234_5678};
  localparam logic [31:0] MB [6] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'h8000_0000,
                                     32'hFFFF_FFFA, 32'h0000_0010};
  localparam logic [31:0] MR [6] = '{32'hFFFF_FFEB, 32'h0, 32'h8000_0000, 32'h0, 32'd30,
                                     32'h2345_6780};
  localparam logic        ME [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  localparam logic [31:0] DA [5] = '{32'hFFFF_FF9C, 32'd5, 32'h8000_0000, 32'd1000, 32'd100};
  localparam logic [31:0] DB [5] = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFF9};
  localparam logic [31:0] DR [5] = '{32'hFFFF_FFF2, 32'h0, 32'h8000_0000, 32'd100,
                                     32'hFFFF_FFF2};
  localparam logic        DE [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 clock = ~clock;

  multdiv_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .ctrl_MULT      (cm),
    .ctrl_DIV       (cd),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (bsy)
  );

  // Returns 1ns after the start edge S; operands are scrambled to prove they are latched.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    opa = a; opb = b; cm = m; cd = d;
    @(posedge clock);
    #1;
    cm = 1'b0; cd = 1'b0;
    opa = 32'hA5A5_5A5A; opb = 32'h0F0F_F0F0;
  endtask

  // Counts edges after S until ready; 40 means it never came.
  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cm = 1'b0; cd = 1'b0; opa = '0; opb = '0;
    #12;
    checks++;
    if ({res, exc, rdy, bsy} !== 35'b0)
      $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b busy=%b expected all zero",
               res, exc, rdy, bsy);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mult();
    int n;
    for (int i = 0; i < 6; i++) begin
      start_op(1'b1, 1'b0, MA[i], MB[i]);
      checks++;
      if (bsy !== 1'b1) $display("FAIL mult_busy[%0d]: got %b expected 1", i, bsy);
      else passed++;
      wait_ready(n);
      checks++;
      if (n != 32) $display("FAIL mult_latency[%0d]: got %0d expected 32", i, n);
      else passed++;
      checks++;
      if (res !== MR[i]) $display("FAIL mult_result[%0d]: got %h expected %h", i, res, MR[i]);
      else passed++;
      checks++;
      if (exc !== ME[i]) $display("FAIL mult_exc[%0d]: got %b expected %b", i, exc, ME[i]);
      else passed++;
      checks++;
      if (bsy !== 1'b0) $display("FAIL mult_busy_done[%0d]: got %b expected 0", i, bsy);
      else passed++;
    end
  endtask

  task automatic test_div();
    int n;
    logic [31:0] er;
    logic        ee;
    for (int i = 0; i < 5; i++) begin
      er = DivEn ? DR[i] : 32'h0;
      ee = DivEn ? DE[i] : 1'b1;
      start_op(1'b0, 1'b1, DA[i], DB[i]);
      checks++;
      if (bsy !== DivEn) $display("FAIL div_busy[%0d]: got %b expected %b", i, bsy, DivEn);
      else passed++;
      wait_ready(n);
      checks++;
      if (n != (DivEn ? 32 : 0))
        $display("FAIL div_latency[%0d]: got %0d expected %0d", i, n, DivEn ? 32 : 0);
      else passed++;
      checks++;
      if (res !== er) $display("FAIL div_result[%0d]: got %h expected %h", i, res, er);
      else passed++;
      checks++;
      if (exc !== ee) $display("FAIL div_exc[%0d]: got %b expected %b", i, exc, ee);
      else passed++;
    end
  endtask

  task automatic test_both_ctrl();
    int n;
    start_op(1'b1, 1'b1, 32'd6, 32'd2);
    wait_ready(n);
    checks++;
    if (n != 32 || res !== 32'd12 || exc !== 1'b0)
      $display("FAIL both_ctrl: got lat=%0d res=%h exc=%b expected lat=32 res=0000000c exc=0",
               n, res, exc);
    else passed++;
  endtask

  task automatic test_ignore_in_run();
    int n;
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (9) @(posedge clock);
    @(negedge clock);
    cd = 1'b1; opa = 32'd100; opb = 32'd7;
    @(posedge clock);
    #1;
    cd = 1'b0;
    wait_ready(n);
    checks++;
    if (n + 10 != 32) $display("FAIL ignore_latency: got %0d expected 32", n + 10);
    else passed++;
    checks++;
    if (res !== 32'hFFFF_FFEB || exc !== 1'b0)
      $display("FAIL ignore_result: got %h/%b expected ffffffeb/0", res, exc);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_ready(n1);
    checks++;
    if (res !== 32'hFFFF_FFEB) $display("FAIL b2b_first: got %h expected ffffffeb", res);
    else passed++;
    start_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    wait_ready(n2);
    checks++;
    if (n2 + 1 != 33) $display("FAIL b2b_spacing: got %0d expected 33", n2 + 1);
    else passed++;
    checks++;
    if (res !== 32'd30 || exc !== 1'b0)
      $display("FAIL b2b_second: got %h/%b expected 0000001e/0", res, exc);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_ready(n);
    start_op(1'b1, 1'b0, 32'h1234_5678, 32'h10);
    repeat (15) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({res, exc, rdy, bsy} !== 35'b0)
      $display("FAIL reset_mid_outputs: got res=%h exc=%b rdy=%b busy=%b expected all zero",
               res, exc, rdy, bsy);
    else passed++;
    #20;
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (rdy) pulses++;
    end
    checks++;
    if (pulses != 0) $display("FAIL reset_mid_no_ready: got %0d pulses expected 0", pulses);
    else passed++;
    start_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    wait_ready(n);
    checks++;
    if (n != 32 || res !== 32'd30 || exc !== 1'b0)
      $display("FAIL reset_mid_recover: got lat=%0d res=%h exc=%b expected 32/0000001e/0",
               n, res, exc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_both_ctrl();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
